// File: rtl/onchip_ram_avs_if.sv
// Avalon-MM slave bus bundle for onchip_ram_avs.
// Request fields flow master -> slave; read data, valid and waitrequest flow back.
interface onchip_ram_avs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic                      chipselect;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      read;
    logic                      write;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      readdatavalid;
    logic                      waitrequest;

    modport master (
        output chipselect, address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, address, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_ram_avs.sv
// On-chip RAM behind an Avalon-MM slave with pipelined reads (1 or 2 cycles).
// Optional power-up/reset clear of every word is built only when the macro
// ONCHIP_RAM_AVS_CLEAR_EN is defined; otherwise the block is ready right after
// reset and keeps its INIT_FILE image or earlier writes.
// clken low or reset_req high freezes memory, read pipeline and clear FSM.
module onchip_ram_avs #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "onchip_ram_avs.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    onchip_ram_avs_if.slave   bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    // Image loaded by the FPGA tool at configuration time.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  enable;
    logic                  clearing;
    logic                  accept;
    logic                  in_range;
    logic                  wr_go;
    logic                  rd_go;
    logic [IDX_W-1:0]      idx;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [NB-1:0]         mem_be;

    logic [READ_LATENCY:1] vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [READ_LATENCY:1];

    assign enable = clken & ~reset_req;

`ifdef ONCHIP_RAM_AVS_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t           state, state_nx;
    logic [IDX_W-1:0] clear_cnt;

    // Clear FSM state and the word pointer it zeroes; reset restarts at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else if (enable) begin
            state <= state_nx;
            if (state == CLEAR) clear_cnt <= clear_cnt + IDX_W'(1);
        end
    end

    // Leave CLEAR once the last word has been zeroed; IDLE holds until reset.
    always_comb begin
        state_nx = state;
        if (state == CLEAR && clear_cnt == IDX_W'(DEPTH - 1)) state_nx = IDLE;
    end

    assign clearing = (state == CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign bus.waitrequest = reset | ~enable | clearing;
    assign accept   = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
    assign in_range = {1'b0, bus.address} < DEPTH_A;
    assign idx      = bus.address[IDX_W-1:0];
    // Write wins over a simultaneous read; out-of-range writes are dropped.
    assign wr_go    = accept & bus.write & in_range;
    assign rd_go    = accept & bus.read & ~bus.write;

    // Single write port shared by bus writes and the clear sweep.
    always_comb begin
        mem_we  = wr_go;
        mem_idx = idx;
        mem_wd  = bus.writedata;
        mem_be  = bus.byteenable;
`ifdef ONCHIP_RAM_AVS_CLEAR_EN
        if (clearing && enable && !reset) begin
            mem_we  = 1'b1;
            mem_idx = clear_cnt;
            mem_wd  = '0;
            mem_be  = '1;
        end
`endif
    end

    // Byte-masked memory write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    // Read pipeline: stage 1 samples the array, later stages just carry data.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int s = 1; s <= READ_LATENCY; s++) dat_pipe[s] <= '0;
        end else if (enable) begin
            vld_pipe[1] <= rd_go;
            dat_pipe[1] <= in_range ? mem[idx] : '0;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign bus.readdatavalid = vld_pipe[READ_LATENCY] & enable & ~reset;
    assign bus.readdata      = dat_pipe[READ_LATENCY];

endmodule

// File: tb/tb_onchip_ram_avs.sv
// Self-checking bench for onchip_ram_avs: instance 0 uses defaults (latency 1,
// 5120 words), instance 1 uses latency 2 and 16 words. A queue-based reference
// model tracks memory contents and outstanding reads in units of enabled cycles.
module tb_onchip_ram_avs;
    localparam int D0 = 5120;
    localparam int D1 = 16;
`ifdef ONCHIP_RAM_AVS_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clken, reset_req;
    logic        cs [2];
    logic        rd [2];
    logic        wr [2];
    logic [12:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];

    onchip_ram_avs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) bus0 ();
    onchip_ram_avs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) bus1 ();

    assign bus0.chipselect = cs[0];
    assign bus0.read       = rd[0];
    assign bus0.write      = wr[0];
    assign bus0.address    = addr[0];
    assign bus0.byteenable = be[0];
    assign bus0.writedata  = wd[0];
    assign bus1.chipselect = cs[1];
    assign bus1.read       = rd[1];
    assign bus1.write      = wr[1];
    assign bus1.address    = addr[1];
    assign bus1.byteenable = be[1];
    assign bus1.writedata  = wd[1];

    onchip_ram_avs #(.DEPTH(D0), .READ_LATENCY(1)) u_ram0 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .bus(bus0));
    onchip_ram_avs #(.DEPTH(D1), .READ_LATENCY(2)) u_ram1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .bus(bus1));

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        int          due;
    } rd_t;

    logic [31:0] mem_m [2][D0];
    bit          known [2][D0];
    rd_t         q [2][$];
    int          en_cnt = 0;
    int          clear_left [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bb_vals [4];

    logic        obs_wait [2], obs_rdv [2], exp_wait [2], exp_rdv [2];
    logic [31:0] obs_rdata [2], exp_rdata [2];

    function automatic int depth_of(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int rl_of(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Sample outputs for the current cycle, predict them, then advance one edge.
    task automatic step();
        logic en, acc;
        rd_t  e;
        #1;
        en = clken & ~reset_req;
        obs_wait[0] = bus0.waitrequest;  obs_wait[1] = bus1.waitrequest;
        obs_rdv[0]  = bus0.readdatavalid; obs_rdv[1] = bus1.readdatavalid;
        obs_rdata[0] = bus0.readdata;    obs_rdata[1] = bus1.readdata;
        for (int i = 0; i < 2; i++) begin
            exp_wait[i]  = reset | ~en | (clear_left[i] > 0);
            exp_rdv[i]   = !reset && en && q[i].size() > 0 && q[i][0].due == en_cnt;
            exp_rdata[i] = exp_rdv[i] ? q[i][0].d : 32'h0;
        end
        for (int i = 0; i < 2; i++) begin
            acc = !exp_wait[i] && cs[i] && (rd[i] || wr[i]);
            if (reset) begin
                q[i].delete();
                clear_left[i] = CLEAR_EN ? depth_of(i) : 0;
                if (CLEAR_EN) begin
                    for (int a = 0; a < depth_of(i); a++) begin
                        mem_m[i][a] = 32'h0;
                        known[i][a] = 1'b1;
                    end
                end
            end else if (en) begin
                if (exp_rdv[i]) void'(q[i].pop_front());
                if (clear_left[i] > 0) clear_left[i]--;
                if (acc && wr[i]) begin
                    if (int'(addr[i]) < depth_of(i)) begin
                        for (int b = 0; b < 4; b++)
                            if (be[i][b]) mem_m[i][addr[i]][8*b +: 8] = wd[i][8*b +: 8];
                        if (be[i] == 4'hF) known[i][addr[i]] = 1'b1;
                    end
                end else if (acc && rd[i]) begin
                    e.d   = (int'(addr[i]) < depth_of(i)) ? mem_m[i][addr[i]] : 32'h0;
                    e.due = en_cnt + rl_of(i);
                    q[i].push_back(e);
                end
            end
        end
        if (!reset && en) en_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; be[i] = '0; wd[i] = '0;
        end
    endtask

    task automatic drive_write(int i, logic [12:0] a, logic [3:0] b, logic [31:0] d);
        idle();
        cs[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; be[i] = b; wd[i] = d;
        step();
        idle();
    endtask

    // Issue one read and wait a bounded number of cycles for its data.
    task automatic read_word(int i, logic [12:0] a, output logic [31:0] d, output int lat);
        idle();
        cs[i] = 1'b1; rd[i] = 1'b1; addr[i] = a;
        step();
        idle();
        d = 32'h0; lat = -1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (obs_rdv[i] === 1'b1) begin
                d = obs_rdata[i]; lat = n;
                break;
            end
        end
    endtask

    task automatic wait_ready(output int fr0, output int fr1, output int mism);
        fr0 = -1; fr1 = -1; mism = 0;
        for (int n = 0; n < 5400; n++) begin
            step();
            if (obs_wait[0] !== exp_wait[0] || obs_wait[1] !== exp_wait[1]) mism++;
            if (fr0 < 0 && obs_wait[0] === 1'b0) fr0 = n;
            if (fr1 < 0 && obs_wait[1] === 1'b0) fr1 = n;
            if (fr0 >= 0 && fr1 >= 0) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int fr0, fr1, mism;
        idle();
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_wait[i] !== 1'b1 || obs_rdv[i] !== 1'b0 || obs_rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state inst%0d: wait=%b rdv=%b rdata=%h, want 1 0 0",
                         i, obs_wait[i], obs_rdv[i], obs_rdata[i]);
            end
        end
        reset = 1'b0;
        wait_ready(fr0, fr1, mism);
        checks++;
        if (fr0 !== (CLEAR_EN ? D0 : 0)) begin
            errors++;
            $display("FAIL ready_after_reset inst0: got %0d want %0d", fr0, CLEAR_EN ? D0 : 0);
        end
        checks++;
        if (fr1 !== (CLEAR_EN ? D1 : 0)) begin
            errors++;
            $display("FAIL ready_after_reset inst1: got %0d want %0d", fr1, CLEAR_EN ? D1 : 0);
        end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL waitrequest_trace: %0d cycles differ, want 0", mism);
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        int lat;
        drive_write(0, 13'h005, 4'hF, 32'hDEADBEEF);
        read_word(0, 13'h005, d, lat);
        checks++;
        if (d !== 32'hDEADBEEF || lat !== 1) begin
            errors++;
            $display("FAIL full_write: got %h lat %0d want deadbeef lat 1", d, lat);
        end
        drive_write(0, 13'h005, 4'h2, 32'h00001100);
        read_word(0, 13'h005, d, lat);
        checks++;
        if (d !== 32'hDEAD11EF || lat !== 1) begin
            errors++;
            $display("FAIL byte_write: got %h lat %0d want dead11ef lat 1", d, lat);
        end
    endtask

    task automatic test_back_to_back();
        int hit_cyc [4];
        logic [31:0] hit_dat [4];
        int nhit = 0;
        for (int a = 0; a < 4; a++) begin
            bb_vals[a] = $urandom;
            drive_write(1, 13'(a), 4'hF, bb_vals[a]);
        end
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 4) begin cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 13'(c); end
            step();
            if (obs_rdv[1] === 1'b1 && nhit < 4) begin
                hit_cyc[nhit] = c; hit_dat[nhit] = obs_rdata[1]; nhit++;
            end
        end
        idle();
        checks++;
        if (nhit !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses want 4", nhit);
        end
        for (int k = 0; k < nhit; k++) begin
            checks++;
            if (hit_cyc[k] !== k + 2 || hit_dat[k] !== bb_vals[k]) begin
                errors++;
                $display("FAIL b2b_beat%0d: cycle %0d data %h want cycle %0d data %h",
                         k, hit_cyc[k], hit_dat[k], k + 2, bb_vals[k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        int lat;
        drive_write(0, 13'd1024, 4'hF, 32'h12345678);
        drive_write(0, 13'h1400, 4'hF, 32'hFFFFFFFF);
        read_word(0, 13'h1400, d, lat);
        checks++;
        if (d !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL oor_read inst0: got %h lat %0d want 0 lat 1", d, lat);
        end
        read_word(0, 13'd1024, d, lat);
        checks++;
        if (d !== 32'h12345678) begin
            errors++;
            $display("FAIL oor_alias inst0: got %h want 12345678", d);
        end
        drive_write(1, 13'd0, 4'hF, 32'hA5A5A5A5);
        drive_write(1, 13'd16, 4'hF, 32'h5A5A5A5A);
        read_word(1, 13'd0, d, lat);
        checks++;
        if (d !== 32'hA5A5A5A5 || lat !== 2) begin
            errors++;
            $display("FAIL oor_alias inst1: got %h lat %0d want a5a5a5a5 lat 2", d, lat);
        end
        read_word(1, 13'd16, d, lat);
        checks++;
        if (d !== 32'h0 || lat !== 2) begin
            errors++;
            $display("FAIL oor_read inst1: got %h lat %0d want 0 lat 2", d, lat);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] hd, d;
        int hit, wait_bad, frz, lat;
        drive_write(0, 13'd7, 4'hF, 32'h0BADF00D);
        for (int v = 0; v < 2; v++) begin
            frz = (v == 0) ? 3 : 2;
            hit = -1; wait_bad = 0; hd = 32'h0;
            for (int c = 0; c < 13; c++) begin
                idle();
                clken = 1'b1; reset_req = 1'b0;
                if (c == 0) begin cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 13'd2; end
                if (c >= 1 && c <= frz) begin
                    if (v == 0) clken = 1'b0; else reset_req = 1'b1;
                    cs[0] = 1'b1; wr[0] = 1'b1; addr[0] = 13'd7; be[0] = 4'hF; wd[0] = 32'hFFFFFFFF;
                end
                step();
                if (c >= 1 && c <= frz && (obs_wait[0] !== 1'b1 || obs_wait[1] !== 1'b1)) wait_bad++;
                if (obs_rdv[1] === 1'b1 && hit < 0) begin hit = c; hd = obs_rdata[1]; end
            end
            idle(); clken = 1'b1; reset_req = 1'b0;
            checks++;
            if (hit !== 2 + frz || hd !== bb_vals[2]) begin
                errors++;
                $display("FAIL freeze_v%0d: pulse at %0d data %h want %0d data %h",
                         v, hit, hd, 2 + frz, bb_vals[2]);
            end
            checks++;
            if (wait_bad !== 0) begin
                errors++;
                $display("FAIL freeze_wait_v%0d: %0d frozen cycles without waitrequest, want 0", v, wait_bad);
            end
        end
        read_word(0, 13'd7, d, lat);
        checks++;
        if (d !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL frozen_write_ignored: got %h want 0badf00d", d);
        end
    endtask

    task automatic test_rw_same();
        logic [31:0] dv, d;
        int n, lat;
        dv = $urandom;
        idle();
        cs[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 13'h010; be[0] = 4'hF; wd[0] = dv;
        step();
        idle();
        n = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (obs_rdv[0] === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL rw_no_valid: got %0d pulses want 0", n);
        end
        read_word(0, 13'h010, d, lat);
        checks++;
        if (d !== dv) begin
            errors++;
            $display("FAIL rw_write_lands: got %h want %h", d, dv);
        end
    endtask

    task automatic test_random();
        int op, r, dep;
        logic [12:0] a;
        for (int c = 0; c < 400; c++) begin
            idle();
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 2; i++) begin
                dep = depth_of(i);
                r = $urandom_range(0, 9);
                if (r == 0) a = 13'($urandom_range(dep, 8191));
                else        a = 13'($urandom_range(0, (i == 0) ? 31 : 15));
                op = $urandom_range(0, 3);
                be[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
                if (op == 2 && int'(a) < dep && !known[i][a]) begin op = 1; be[i] = 4'hF; end
                cs[i] = (op != 0); wr[i] = (op == 1 || op == 3); rd[i] = (op == 2 || op == 3);
                addr[i] = a; wd[i] = $urandom;
            end
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_wait[i] !== exp_wait[i] || obs_rdv[i] !== exp_rdv[i] ||
                    (exp_rdv[i] && obs_rdata[i] !== exp_rdata[i])) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: wait=%b rdv=%b data=%h want %b %b %h",
                             c, i, obs_wait[i], obs_rdv[i], obs_rdata[i],
                             exp_wait[i], exp_rdv[i], exp_rdata[i]);
                end
            end
        end
        idle(); clken = 1'b1; reset_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rdv[i] !== exp_rdv[i] || (exp_rdv[i] && obs_rdata[i] !== exp_rdata[i])) begin
                    errors++;
                    $display("FAIL drain c%0d inst%0d: rdv=%b data=%h want %b %h",
                             c, i, obs_rdv[i], obs_rdata[i], exp_rdv[i], exp_rdata[i]);
                end
            end
        end
    endtask

    task automatic test_midclear_reset();
        int n, fr0, fr1, mism, lat;
        logic [31:0] d, want;
        idle();
        cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 13'd0;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (obs_rdv[1] === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL inflight_discard: got %0d pulses want 0", n);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(fr0, fr1, mism);
        checks++;
        if (fr1 !== (CLEAR_EN ? D1 : 0) || fr0 !== (CLEAR_EN ? D0 : 0)) begin
            errors++;
            $display("FAIL restart_clear: ready %0d/%0d want %0d/%0d",
                     fr0, fr1, CLEAR_EN ? D0 : 0, CLEAR_EN ? D1 : 0);
        end
        for (int w = 0; w < D1; w++) begin
            if (CLEAR_EN || known[1][w]) begin
                want = CLEAR_EN ? 32'h0 : mem_m[1][w];
                read_word(1, 13'(w), d, lat);
                checks++;
                if (d !== want || lat !== 2) begin
                    errors++;
                    $display("FAIL post_reset_word%0d: got %h lat %0d want %h lat 2", w, d, lat, want);
                end
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        test_reset();
        test_byteenable();
        test_back_to_back();
        test_out_of_range();
        test_freeze();
        test_rw_same();
        test_random();
        test_midclear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL timeout: bench still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
